// File: rtl/gb_alu_pkg.sv
// -----------------------------------------------------------------------------
// gb_alu_pkg
// Shared definitions for the 64-bit ALU shift pipe:
//   - shift op encoding (gb_shift_op_e, constants GB_SHIFT_SLL .. GB_SHIFT_SRAW)
//   - stage 1 payload struct (op, normalised base, effective shamt, tag)
//   - small decode helpers used by the pipe
// Tags are carried in a fixed-width field of GB_TAG_W_MAX bits; the pipe
// uses only the low TAG_W bits, so TAG_W must not exceed GB_TAG_W_MAX.
// -----------------------------------------------------------------------------
package gb_alu_pkg;

    localparam int GB_TAG_W_MAX = 16;

    // Encodings 3'b011 and 3'b111 are reserved and intentionally unnamed.
    typedef enum logic [2:0] {
        GB_SHIFT_SLL  = 3'b000,
        GB_SHIFT_SRL  = 3'b001,
        GB_SHIFT_SRA  = 3'b010,
        GB_SHIFT_SLLW = 3'b100,
        GB_SHIFT_SRLW = 3'b101,
        GB_SHIFT_SRAW = 3'b110
    } gb_shift_op_e;

    typedef struct packed {
        gb_shift_op_e              op;
        logic [63:0]               base;
        logic [6:0]                shamt;
        logic [GB_TAG_W_MAX-1:0]   tag;
    } gb_shift_s1_t;

    // Word forms have bit 2 of the encoding set.
    function automatic logic gb_is_word(input logic [2:0] op);
        return op[2];
    endfunction

    // Reserved encodings have both low bits set.
    function automatic logic gb_is_reserved(input logic [2:0] op);
        return (op[1:0] == 2'b11);
    endfunction

endpackage

// File: rtl/gb_alu_shift_core.sv
// -----------------------------------------------------------------------------
// gb_alu_shift_core
// Purely combinational 64-bit barrel shifter.
// Ports:
//   i_data      64-bit operand
//   i_shamt     7-bit shift amount; values >= 64 shift everything out
//   i_dir_right 1 = shift right, 0 = shift left
//   i_arith     1 = arithmetic right shift (fill with i_data[63])
//   o_data      shifted value
// -----------------------------------------------------------------------------
module gb_alu_shift_core (
    input  logic [63:0] i_data,
    input  logic [6:0]  i_shamt,
    input  logic        i_dir_right,
    input  logic        i_arith,
    output logic [63:0] o_data
);

    // Barrel shift; amounts of 64 or more saturate to all-zero or all-sign.
    always_comb begin
        o_data = 64'd0;
        if (i_shamt[6]) begin
            if (i_dir_right && i_arith) begin
                o_data = {64{i_data[63]}};
            end else begin
                o_data = 64'd0;
            end
        end else if (i_dir_right) begin
            if (i_arith) begin
                o_data = $unsigned($signed(i_data) >>> i_shamt[5:0]);
            end else begin
                o_data = i_data >> i_shamt[5:0];
            end
        end else begin
            o_data = i_data << i_shamt[5:0];
        end
    end

endmodule

// File: rtl/gb_alu_shift_pipe.sv
// -----------------------------------------------------------------------------
// gb_alu_shift_pipe
// Two-stage pipelined shift unit. Stage 1 captures op/tag and the normalised
// operand (word forms reduced to 32 bits, zero- or sign-extended); stage 2
// performs the barrel shift and holds result/tag under valid/ready.
// Optional build macro: GB_ALU_SHIFT_MASK_EN
//   defined   -> shamt masked to [5:0] (doubleword) / [4:0] (word)
//   undefined -> full 7-bit shamt; large amounts shift everything out
// Ports:
//   i_clk, i_rst (sync, active-high), i_flush (kills in-flight ops)
//   i_valid/o_ready             issue handshake
//   i_op, i_base, i_shamt, i_tag  micro-op fields
//   o_valid/i_ready             writeback handshake
//   o_result, o_tag             registered result and its tag
// -----------------------------------------------------------------------------
module gb_alu_shift_pipe
    import gb_alu_pkg::*;
#(
    parameter int TAG_W = 5
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_flush,
    input  logic             i_valid,
    output logic             o_ready,
    input  logic [2:0]       i_op,
    input  logic [63:0]      i_base,
    input  logic [6:0]       i_shamt,
    input  logic [TAG_W-1:0] i_tag,
    output logic             o_valid,
    input  logic             i_ready,
    output logic [63:0]      o_result,
    output logic [TAG_W-1:0] o_tag
);

    logic               r_s1_valid;
    gb_shift_s1_t       r_s1;
    logic               r_o_valid;
    logic [63:0]        r_result;
    logic [TAG_W-1:0]   r_tag;

    logic               w_s2_can_load;
    logic               w_ready;
    logic               w_accept;
    gb_shift_s1_t       w_s1_next;
    logic [GB_TAG_W_MAX-1:0] w_tag_ext;
    logic               w_dir_right;
    logic               w_arith;
    logic               w_reserved;
    logic [63:0]        w_shifted;
    logic [63:0]        w_result;

    // Handshake: ready is forced low while reset or flush is active.
    assign w_s2_can_load = !r_o_valid || i_ready;
    assign w_ready       = !i_rst && !i_flush && (!r_s1_valid || w_s2_can_load);
    assign w_accept      = i_valid && w_ready;

    // Stage 1 operand normalisation and effective shift amount.
    always_comb begin
        w_s1_next = '0;
        w_tag_ext = '0;
        w_tag_ext[TAG_W-1:0] = i_tag;
        w_s1_next.op  = gb_shift_op_e'(i_op);
        w_s1_next.tag = w_tag_ext;
        case (i_op)
            GB_SHIFT_SLLW, GB_SHIFT_SRLW: w_s1_next.base = {32'd0, i_base[31:0]};
            GB_SHIFT_SRAW:                w_s1_next.base = {{32{i_base[31]}}, i_base[31:0]};
            default:                      w_s1_next.base = i_base;
        endcase
`ifdef GB_ALU_SHIFT_MASK_EN
        if (gb_is_word(i_op)) begin
            w_s1_next.shamt = {2'b00, i_shamt[4:0]};
        end else begin
            w_s1_next.shamt = {1'b0, i_shamt[5:0]};
        end
`else
        w_s1_next.shamt = i_shamt;
`endif
    end

    // Stage 1 register: fills on accept, empties when stage 2 takes it.
    always_ff @(posedge i_clk) begin
        if (i_rst || i_flush) begin
            r_s1_valid <= 1'b0;
            r_s1       <= '0;
        end else if (w_accept) begin
            r_s1_valid <= 1'b1;
            r_s1       <= w_s1_next;
        end else if (r_s1_valid && w_s2_can_load) begin
            r_s1_valid <= 1'b0;
        end else begin
            r_s1_valid <= r_s1_valid;
        end
    end

    // Stage 2 shift control decode.
    always_comb begin
        w_dir_right = 1'b0;
        w_arith     = 1'b0;
        w_reserved  = 1'b0;
        case (r_s1.op)
            GB_SHIFT_SLL, GB_SHIFT_SLLW: begin
                w_dir_right = 1'b0;
                w_arith     = 1'b0;
            end
            GB_SHIFT_SRL, GB_SHIFT_SRLW: begin
                w_dir_right = 1'b1;
                w_arith     = 1'b0;
            end
            GB_SHIFT_SRA, GB_SHIFT_SRAW: begin
                w_dir_right = 1'b1;
                w_arith     = 1'b1;
            end
            default: begin
                w_reserved  = 1'b1;
            end
        endcase
    end

    gb_alu_shift_core u_core (
        .i_data      (r_s1.base),
        .i_shamt     (r_s1.shamt),
        .i_dir_right (w_dir_right),
        .i_arith     (w_arith),
        .o_data      (w_shifted)
    );

    // Word results: the pre-normalised operand makes bits [31:0] correct for
    // any shamt, so only the final sign extension from bit 31 is needed.
    always_comb begin
        w_result = 64'd0;
        if (w_reserved) begin
            w_result = 64'd0;
        end else if (gb_is_word(r_s1.op)) begin
            w_result = {{32{w_shifted[31]}}, w_shifted[31:0]};
        end else begin
            w_result = w_shifted;
        end
    end

    // Stage 2 register: loads when empty or when writeback consumes it.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_o_valid <= 1'b0;
            r_result  <= 64'd0;
            r_tag     <= '0;
        end else if (i_flush) begin
            r_o_valid <= 1'b0;
        end else if (w_s2_can_load) begin
            r_o_valid <= r_s1_valid;
            if (r_s1_valid) begin
                r_result <= w_result;
                r_tag    <= r_s1.tag[TAG_W-1:0];
            end else begin
                r_result <= r_result;
                r_tag    <= r_tag;
            end
        end else begin
            r_o_valid <= r_o_valid;
        end
    end

    assign o_ready  = w_ready;
    assign o_valid  = r_o_valid;
    assign o_result = r_result;
    assign o_tag    = r_tag;

endmodule

// File: tb/tb_gb_alu_shift_pipe.sv
module tb_gb_alu_shift_pipe;
    import gb_alu_pkg::*;

    localparam int TAG_W = 5;

`ifdef GB_ALU_SHIFT_MASK_EN
    localparam logic [63:0] EXP_SLL64   = 64'h0123_4567_89AB_CDEF;
    localparam logic [63:0] EXP_SRA70   = 64'hFE00_0000_0000_0000;
    localparam logic [63:0] EXP_SRAW40  = 64'hFFFF_FFFF_FF80_0000;
    localparam logic [63:0] EXP_SLLW33  = 64'h0000_0000_0000_0002;
    localparam logic [63:0] EXP_SRA100  = 64'h0000_0000_07FF_FFFF;
`else
    localparam logic [63:0] EXP_SLL64   = 64'h0000_0000_0000_0000;
    localparam logic [63:0] EXP_SRA70   = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_SRAW40  = 64'hFFFF_FFFF_FFFF_FFFF;
    localparam logic [63:0] EXP_SLLW33  = 64'h0000_0000_0000_0000;
    localparam logic [63:0] EXP_SRA100  = 64'h0000_0000_0000_0000;
`endif

    logic             i_clk = 1'b0;
    logic             i_rst, i_flush, i_valid, i_ready;
    logic             o_ready, o_valid;
    logic [2:0]       i_op;
    logic [63:0]      i_base, o_result;
    logic [6:0]       i_shamt;
    logic [TAG_W-1:0] i_tag, o_tag;

    typedef struct {
        logic [63:0]      res;
        logic [TAG_W-1:0] tag;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec  = 0;
    int   n_miss = 0;

    gb_alu_shift_pipe #(.TAG_W(TAG_W)) dut (
        .i_clk    (i_clk),
        .i_rst    (i_rst),
        .i_flush  (i_flush),
        .i_valid  (i_valid),
        .o_ready  (o_ready),
        .i_op     (i_op),
        .i_base   (i_base),
        .i_shamt  (i_shamt),
        .i_tag    (i_tag),
        .o_valid  (o_valid),
        .i_ready  (i_ready),
        .o_result (o_result),
        .o_tag    (o_tag)
    );

    always #5 i_clk = ~i_clk;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h, required %h", name, act, exp);
        end
    endtask

    // Monitor: pops one expectation per consumed result.
    always @(negedge i_clk) begin : monitor
        exp_t e;
        if (!i_rst && o_valid && i_ready) begin
            if (sb_q.size() == 0) begin
                n_vec++;
                n_miss++;
                $display("FAIL unexpected_output: got result %h tag %h, required no output", o_result, o_tag);
            end else begin
                e = sb_q.pop_front();
                check("result", o_result, e.res);
                check("tag", {59'd0, o_tag}, {59'd0, e.tag});
            end
        end
    end

    // Hold an op on the issue port until accepted, then record its expectation.
    task automatic issue(input logic [2:0] op, input logic [63:0] base, input logic [6:0] sh,
                         input logic [TAG_W-1:0] tag, input logic [63:0] exp);
        exp_t e;
        bit   ok;
        ok      = 1'b0;
        i_valid = 1'b1;
        i_op    = op;
        i_base  = base;
        i_shamt = sh;
        i_tag   = tag;
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge i_clk);
            if (o_ready) begin
                e.res = exp;
                e.tag = tag;
                sb_q.push_back(e);
                ok = 1'b1;
            end
        end
        if (!ok) begin
            n_vec++;
            n_miss++;
            $display("FAIL issue_timeout: o_ready 0 for 40 cycles, required 1");
        end
        @(posedge i_clk);
        #1;
        i_valid = 1'b0;
    endtask

    task automatic drain();
        for (int k = 0; k < 50 && sb_q.size() != 0; k++) @(negedge i_clk);
        check("drain_pending", 64'(sb_q.size()), 64'd0);
        @(posedge i_clk);
        #1;
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        i_rst = 1'b1; i_flush = 1'b0; i_valid = 1'b0; i_ready = 1'b1;
        i_op = 3'd0; i_base = 64'd0; i_shamt = 7'd0; i_tag = '0;

        // Reset behaviour
        repeat (3) @(posedge i_clk);
        @(negedge i_clk);
        check("ready_in_reset", {63'd0, o_ready}, 64'd0);
        check("valid_in_reset", {63'd0, o_valid}, 64'd0);
        @(posedge i_clk); #1;
        i_rst = 1'b0;
        @(negedge i_clk);
        check("ready_after_reset", {63'd0, o_ready}, 64'd1);
        check("valid_after_reset", {63'd0, o_valid}, 64'd0);
        check("result_after_reset", o_result, 64'd0);
        check("tag_after_reset", {59'd0, o_tag}, 64'd0);
        @(posedge i_clk); #1;

        // Single op: result appears two edges after presentation
        issue(GB_SHIFT_SRA, 64'h8000_0000_0000_0000, 7'd4, 5'h0A, 64'hF800_0000_0000_0000);
        @(negedge i_clk);
        check("latency_early", {63'd0, o_valid}, 64'd0);
        @(negedge i_clk);
        check("latency_two", {63'd0, o_valid}, 64'd1);
        @(posedge i_clk); #1;

        // Back-to-back directed vectors with i_ready held high
        issue(GB_SHIFT_SRAW, 64'h0000_0000_8000_0000, 7'd31,  5'd2,  64'hFFFF_FFFF_FFFF_FFFF);
        issue(GB_SHIFT_SRLW, 64'hFFFF_FFFF_8000_0000, 7'd1,   5'd3,  64'h0000_0000_4000_0000);
        issue(GB_SHIFT_SLL,  64'h0123_4567_89AB_CDEF, 7'd64,  5'd4,  EXP_SLL64);
        issue(GB_SHIFT_SLL,  64'h0123_4567_89AB_CDEF, 7'd4,   5'd5,  64'h1234_5678_9ABC_DEF0);
        issue(GB_SHIFT_SRL,  64'h8000_0000_0000_0001, 7'd63,  5'd6,  64'h0000_0000_0000_0001);
        issue(GB_SHIFT_SLLW, 64'h0000_0000_4000_0001, 7'd1,   5'd7,  64'hFFFF_FFFF_8000_0002);
        issue(3'b011,        64'hFFFF_FFFF_FFFF_FFFF, 7'd1,   5'd8,  64'h0000_0000_0000_0000);
        issue(GB_SHIFT_SRA,  64'h8000_0000_0000_0000, 7'd70,  5'd9,  EXP_SRA70);
        issue(GB_SHIFT_SRAW, 64'h0000_0000_8000_0000, 7'd40,  5'd10, EXP_SRAW40);
        issue(GB_SHIFT_SLLW, 64'h0000_0000_0000_0001, 7'd33,  5'd11, EXP_SLLW33);
        issue(GB_SHIFT_SRA,  64'h7FFF_FFFF_FFFF_FFFF, 7'd100, 5'd12, EXP_SRA100);
        issue(3'b111,        64'h0000_0000_0000_0001, 7'd0,   5'd13, 64'h0000_0000_0000_0000);
        drain();

        // Stall: three ops with writeback held off after the first result
        i_ready = 1'b0;
        fork
            begin
                issue(GB_SHIFT_SLL,  64'h0000_0000_0000_0001, 7'd1, 5'd1, 64'h0000_0000_0000_0002);
                issue(GB_SHIFT_SRL,  64'h0000_0000_0000_0100, 7'd4, 5'd2, 64'h0000_0000_0000_0010);
                issue(GB_SHIFT_SRAW, 64'h0000_0000_F000_0000, 7'd4, 5'd3, 64'hFFFF_FFFF_FF00_0000);
            end
            begin : stall_ctl
                bit seen;
                seen = 1'b0;
                for (int k = 0; k < 20 && !seen; k++) begin
                    @(negedge i_clk);
                    if (o_valid) seen = 1'b1;
                end
                check("stall_first_seen", {63'd0, seen}, 64'd1);
                for (int c = 0; c < 3; c++) begin
                    if (c != 0) @(negedge i_clk);
                    check("stall_ready_low", {63'd0, o_ready}, 64'd0);
                    check("stall_valid_held", {63'd0, o_valid}, 64'd1);
                    check("stall_result_held", o_result, 64'h0000_0000_0000_0002);
                    check("stall_tag_held", {59'd0, o_tag}, 64'd1);
                end
                @(posedge i_clk); #1;
                i_ready = 1'b1;
                @(negedge i_clk);
                check("ready_follows_iready", {63'd0, o_ready}, 64'd1);
            end
        join
        drain();

        // Flush with both stages full
        i_ready = 1'b0;
        issue(GB_SHIFT_SLL, 64'h0000_0000_0000_0001, 7'd2, 5'd4, 64'h0000_0000_0000_0004);
        issue(GB_SHIFT_SLL, 64'h0000_0000_0000_0001, 7'd3, 5'd5, 64'h0000_0000_0000_0008);
        i_flush = 1'b1;
        @(negedge i_clk);
        check("flush_ready_low", {63'd0, o_ready}, 64'd0);
        check("flush_valid_before", {63'd0, o_valid}, 64'd1);
        sb_q.delete();
        @(posedge i_clk); #1;
        i_flush = 1'b0;
        @(negedge i_clk);
        check("flush_valid_cleared", {63'd0, o_valid}, 64'd0);
        check("flush_ready_after", {63'd0, o_ready}, 64'd1);
        @(posedge i_clk); #1;
        i_ready = 1'b1;
        issue(GB_SHIFT_SRL, 64'hFFFF_FFFF_FFFF_FFFF, 7'd60, 5'd6, 64'h0000_0000_0000_000F);
        drain();

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end

endmodule

// File: doc/gb_alu_shift_pipe.md
# gb_alu_shift_pipe

Two-stage pipelined shift execution unit for the 64-bit ALU. It accepts one shift micro-op per cycle from issue and produces a registered result with a tag for writeback. Stage 1 captures and normalises operands for doubleword and word forms. Stage 2 performs the barrel shift and holds the result under a valid/ready handshake with back-pressure and flush.

## Interface
- TAG_W, default 5: width of the opaque destination tag carried alongside each op.
- i_clk  in  1  clock; all state updates on its rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_flush  in  1  synchronous kill of all in-flight ops.
- i_valid  in  1  issue presents an op.
- o_ready  out  1  unit accepts the op this cycle.
- i_op  in  3  000 SLL, 001 SRL, 010 SRA, 100 SLLW, 101 SRLW, 110 SRAW; 011 and 111 are reserved.
- i_base  in  64  operand to shift.
- i_shamt  in  7  shift amount.
- i_tag  in  TAG_W  destination tag.
- o_valid  out  1  result available.
- i_ready  in  1  writeback consumes the result.
- o_result  out  64  shifted value.
- o_tag  out  TAG_W  tag of o_result.

## Operation
- Accept when i_valid && o_ready. Stage 1 then registers op, tag and the normalised operand:
  - W forms: low 32 bits, zero-extended for SRLW and SLLW, sign-extended from bit 31 for SRAW.
- Effective shamt:
  - Without masking: full 7-bit value. Doubleword shifts with shamt ≥ 64 give 0 for SLL/SRL and 64 copies of the sign for SRA. W forms with shamt ≥ 32 give 0 (SLLW/SRLW) or 32 copies of bit 31 (SRAW) before final extension.
  - With masking: see Configuration.
- SRA sign source is operand bit 63; SRAW sign source is operand bit 31.
- W results are sign-extended from result bit 31 to 64 bits.
- Reserved opcodes complete normally with o_result = 0.
- Stage 2 registers the shifted result and tag.
- Flow control per stage: a stage advances when it is empty or its downstream consumer takes its content.
  - o_ready = !s1_valid || s2_can_load.
  - s2_can_load = !o_valid || i_ready.
- i_flush clears s1_valid and o_valid next cycle. o_ready is 0 during a flush cycle, so no op is accepted then.
- When i_rst and i_flush are both high, reset governs; the visible effect is identical.

## Timing
- Latency is 2 cycles: an op accepted at edge N is visible on o_valid/o_result at edge N+2 when there is no stall.
- Throughput is one op per cycle when i_ready is held high.
- When i_ready is low with both stages full, o_ready is 0. o_result and o_tag hold stable until the consume edge.
- After i_ready rises, o_ready rises in the same cycle (combinational path), and a new op may be accepted while stage 1 moves to stage 2.
- Reset values: o_valid 0, o_result 0, o_tag 0, internal s1_valid 0. o_ready reads 1 in the first cycle after reset deasserts.
- o_ready is 0 in any cycle where i_rst or i_flush is high.

## Configuration
- GB_ALU_SHIFT_MASK_EN defined: shamt is masked to i_shamt[5:0] for doubleword ops and i_shamt[4:0] for W ops (RV64 semantics), so a shamt of 64 behaves as 0.
- GB_ALU_SHIFT_MASK_EN undefined: unmasked 7-bit semantics as described in Operation.

## Structure
- Package gb_alu_pkg holds:
  - the op encoding constants (GB_SHIFT_SLL … GB_SHIFT_SRAW);
  - the op typedef;
  - the stage 1 payload struct (op, normalised base, effective shamt, tag).
- Sub-module gb_alu_shift_core is purely combinational. Inputs: 64-bit operand, 7-bit shamt, direction, arithmetic flag. Output: shifted value. It is instantiated once in stage 2, and W-form handling stays in the pipe.

## Test plan
- SRA, base 0x8000_0000_0000_0000, shamt 4, i_ready 1 → o_result 0xF800_0000_0000_0000 two cycles later, with the tag preserved.
- SRAW, base 0x0000_0000_8000_0000, shamt 31 → o_result 0xFFFF_FFFF_FFFF_FFFF.
- SRLW, base 0xFFFF_FFFF_8000_0000, shamt 1 → o_result 0x0000_0000_4000_0000.
- SLL, shamt 64:
  - macro undefined → o_result 0;
  - macro defined → o_result equals base.
- Back-to-back stream of 3 ops with i_ready held low for 3 cycles after the first result appears:
  - o_ready drops once both stages are full;
  - the first result holds stable while stalled;
  - all 3 ops emerge in order with no loss or duplication.
- i_flush asserted with both stages full → o_valid 0 next cycle, o_ready 0 during the flush cycle, and a new op issued afterwards completes with its correct result.
